// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - round-robin arbiter sharing the instruction memory port between fetch and data
`timescale 1ns/1ps

module imem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester (read-only)
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    // data / loader requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_wsz,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    // memory port
    output logic              m_re,
    output logic [ADDR_W-1:0] m_raddr,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [31:0]       m_wdata,
    output logic [2:0]        m_wsz,
    input  logic [31:0]       m_rdata,
    input  logic              m_hit,
    // performance counters
    output logic [CNT_W-1:0]  f_gnt_cnt,
    output logic [CNT_W-1:0]  d_gnt_cnt
);

    typedef enum logic {
        ST_ARB     = 1'b0,
        ST_WR_TURN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    // 0: fetch wins the next contested cycle, 1: data wins it
    logic                r_rr_ptr;
    // in-flight read pipeline: valid bit and owner (1 = data) per stage
    logic [RD_LAT-1:0]   r_pv;
    logic [RD_LAT-1:0]   r_po;
    logic [CNT_W-1:0]    r_f_cnt;
    logic [CNT_W-1:0]    r_d_cnt;

    logic                w_f_elig;
    logic                w_d_elig;
    logic                w_f_gnt;
    logic                w_d_gnt;
    logic                w_d_rd;
    logic                w_d_wr;
    logic                w_rd_gnt;
    logic                w_last_v;
    logic                w_last_d;
    logic                w_f_rsp;
    logic                w_d_rsp;

    // Eligibility and round-robin grant; reset suppresses all grants so the port is quiet while held
    always_comb begin
        w_f_elig = f_req & ~f_flush & (r_state == ST_ARB) & ~rst;
        w_d_elig = d_req & (d_we | (r_state == ST_ARB)) & ~rst;
        w_f_gnt  = w_f_elig & (~w_d_elig | ~r_rr_ptr);
        w_d_gnt  = w_d_elig & (~w_f_elig | r_rr_ptr);
        w_d_rd   = w_d_gnt & ~d_we;
        w_d_wr   = w_d_gnt & d_we;
        w_rd_gnt = w_f_gnt | w_d_rd;
    end

    // Memory port is driven straight from the winning request, zero when idle
    always_comb begin
        m_re    = w_rd_gnt;
        m_raddr = '0;
        m_we    = w_d_wr;
        m_waddr = '0;
        m_wdata = '0;
        m_wsz   = '0;
        if (w_f_gnt) begin
            m_raddr = f_addr;
        end else if (w_d_rd) begin
            m_raddr = d_addr;
        end
        if (w_d_wr) begin
            m_waddr = d_addr;
            m_wdata = d_wdata;
            m_wsz   = d_wsz;
        end
    end

    // Turnaround state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Any granted write forces one bubble cycle in which no read may issue
    always_comb begin
        w_state_nxt = ST_ARB;
        case (r_state)
            ST_ARB:     w_state_nxt = w_d_wr ? ST_WR_TURN : ST_ARB;
            ST_WR_TURN: w_state_nxt = w_d_wr ? ST_WR_TURN : ST_ARB;
            default:    w_state_nxt = ST_ARB;
        endcase
    end

    // Round-robin pointer moves only when someone is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_f_gnt) begin
            r_rr_ptr <= 1'b1;
        end else if (w_d_gnt) begin
            r_rr_ptr <= 1'b0;
        end
    end

    // Read-latency shift register; a flush kills fetch-owned entries as they advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            r_po <= '0;
        end else begin
            r_pv[0] <= w_rd_gnt;
            r_po[0] <= w_d_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1] & ~(f_flush & ~r_po[i-1]);
                r_po[i] <= r_po[i-1];
            end
        end
    end

    // Route the emerging response to its owner; a same-cycle flush also kills the emitting fetch
    always_comb begin
        w_last_v = r_pv[RD_LAT-1];
        w_last_d = r_po[RD_LAT-1];
        w_f_rsp  = w_last_v & ~w_last_d & ~f_flush;
        w_d_rsp  = w_last_v & w_last_d;
        f_rvalid = w_f_rsp;
        f_rdata  = w_f_rsp ? m_rdata : 32'h0;
        f_err    = w_f_rsp & ~m_hit;
        d_rvalid = w_d_rsp;
        d_rdata  = w_d_rsp ? m_rdata : 32'h0;
        d_err    = w_d_rsp & ~m_hit;
        f_gnt    = w_f_gnt;
        d_gnt    = w_d_gnt;
    end

    // Saturating grant counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_cnt <= '0;
            r_d_cnt <= '0;
        end else begin
            if (w_f_gnt && (r_f_cnt != '1)) begin
                r_f_cnt <= r_f_cnt + CNT_ONE;
            end
            if (w_d_gnt && (r_d_cnt != '1)) begin
                r_d_cnt <= r_d_cnt + CNT_ONE;
            end
        end
    end

    assign f_gnt_cnt = r_f_cnt;
    assign d_gnt_cnt = r_d_cnt;

endmodule
